handshake_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one valid/ready downstream channel between NUM_REQ

---
 rtl/handshake_rr_arbiter.sv | 101 ++++++++++
 tb/tb_handshake_rr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/handshake_rr_arbiter.sv
// Round-robin packet arbiter: NUM_REQ valid/ready sources share one registered valid/ready output.
// One cycle of latency at full throughput; while the output register is stalled, every req_ready is held low.
module handshake_rr_arbiter #(
  parameter int WORD_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*WORD_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        down_valid,
  output logic [WORD_WIDTH-1:0]       down_data,
  output logic                        down_last,
  output logic [IDX_W-1:0]            down_src,
  input  logic                        down_ready
);

  typedef enum logic {ARB, HOLD} state_t;

  state_t                state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [IDX_W-1:0]      grant_idx, grant_nxt;
  logic [IDX_W-1:0]      winner, scan_idx, sel;
  logic                  found, can_load, accept, sel_last;
  logic [WORD_WIDTH-1:0] sel_data;

  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
    return (v == IDX_W'(NUM_REQ - 1)) ? '0 : v + 1'b1;
  endfunction

  assign can_load = !down_valid || down_ready;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
      scan_idx = inc_wrap(scan_idx);
    end
  end

  always_comb begin
    sel      = (state == HOLD) ? grant_idx : winner;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == sel) sel_data = req_data[i*WORD_WIDTH +: WORD_WIDTH];
    end
    sel_last  = req_last[sel];
    req_ready = '0;
    if (!rst && (state == HOLD || found)) req_ready[sel] = can_load;
    accept = |(req_valid & req_ready);
  end

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_idx;
    if (accept) begin
      if (sel_last) begin
        state_nxt  = ARB;
        rr_ptr_nxt = inc_wrap(sel);
      end else begin
        state_nxt = HOLD;
        grant_nxt = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      down_valid <= 1'b0;
      down_data  <= '0;
      down_last  <= 1'b0;
      down_src   <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      grant_idx <= grant_nxt;
      if (can_load) begin
        down_valid <= accept;
        if (accept) begin
          down_data <= sel_data;
          down_last <= sel_last;
          down_src  <= sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Randomized bench for handshake_rr_arbiter with a packet-level reference model of the arbitration rules.
module tb_handshake_rr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [N*W-1:0] req_data;
  logic           down_valid, down_last, down_ready;
  logic [W-1:0]   down_data;
  logic [1:0]     down_src;

  handshake_rr_arbiter #(.WORD_WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .down_valid(down_valid), .down_data(down_data), .down_last(down_last), .down_src(down_src),
    .down_ready(down_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: packet ownership, round-robin pointer, and the output beat register.
  logic         m_locked = 1'b0;
  int           m_owner = 0;
  int           m_ptr = 0;
  logic         m_dv = 1'b0;
  logic [W-1:0] m_dd = '0;
  logic         m_dl = 1'b0;
  logic [1:0]   m_ds = '0;

  logic [N-1:0] exp_rdy, acc;
  logic         can, rst_was, found;
  int           a;
  int           rem [N];
  logic [5:0]   seq [N];

  initial begin
    rst        = 1'b1;
    req_valid  = '1;
    req_last   = '1;
    req_data   = 32'h44332211;
    down_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      seq[i] = '0;
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      can     = !m_dv || down_ready;
      exp_rdy = '0;
      if (!rst) begin
        if (m_locked) exp_rdy[m_owner] = can;
        else begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            if (!found && req_valid[(m_ptr + k) % N]) begin
              found = 1'b1;
              exp_rdy[(m_ptr + k) % N] = can;
            end
          end
        end
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("down_valid", 32'(down_valid), 32'(m_dv));
      check("down_data", 32'(down_data), 32'(m_dd));
      check("down_last", 32'(down_last), 32'(m_dl));
      check("down_src", 32'(down_src), 32'(m_ds));
      acc = req_valid & exp_rdy;

      @(posedge clk);
      rst_was = rst;
      if (rst_was) begin
        m_locked = 1'b0; m_owner = 0; m_ptr = 0;
        m_dv = 1'b0; m_dd = '0; m_dl = 1'b0; m_ds = '0;
      end else if (can) begin
        m_dv = |acc;
        if (|acc) begin
          a = 0;
          for (int i = 0; i < N; i++) if (acc[i]) a = i;
          m_dd = req_data[a*W +: W];
          m_dl = req_last[a];
          m_ds = 2'(a);
          if (req_last[a]) begin
            m_locked = 1'b0;
            m_ptr    = (a + 1) % N;
          end else begin
            m_locked = 1'b1;
            m_owner  = a;
          end
        end
      end

      #1;
      rst        = (cyc < 1) ? 1'b1 : ($urandom_range(0, 149) == 0);
      down_ready = ($urandom_range(0, 99) < 75);
      for (int i = 0; i < N; i++) begin
        if (rst_was) begin
          req_valid[i] = 1'b0;
          rem[i] = 0;
        end else if (acc[i]) begin
          req_valid[i] = 1'b0;
        end
        // Sources only raise valid with a fresh beat; a pending beat is never changed.
        if (!req_valid[i] && $urandom_range(0, 99) < 70) begin
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          req_data[i*W +: W] = {2'(i), seq[i]};
          req_last[i]  = (rem[i] == 1);
          rem[i]       = rem[i] - 1;
          seq[i]       = seq[i] + 6'd1;
          req_valid[i] = 1'b1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
